// File: rtl/spm_ctrl_pkg.sv
// spm_ctrl_pkg
// Shared definitions for the spm_ctrl sequencing controller.
//   spm_ctrl_state_t : controller FSM states (IDLE / RUN / DONE)
//   cnt_w(width)     : bit width of the RUN cycle counter, which has to
//                      reach 2*width inclusive
package spm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } spm_ctrl_state_t;

  function automatic int cnt_w(input int width);
    return $clog2(2 * width + 1);
  endfunction

endpackage

// File: rtl/spm_ctrl_spm.sv
// spm
// Serial-parallel signed multiplier. The multiplicand is applied in
// parallel on x; the multiplier arrives one bit per cycle on y, LSB first,
// sign-extended by the driver for as many cycles as product bits are
// wanted. Each cycle one product bit is produced, LSB first, and it appears
// registered on p in the following cycle.
// Ports:
//   clk  in   1     clock, rising edge
//   rst  in   1     asynchronous active-high reset, clears the accumulator
//   x    in   SIZE  signed multiplicand (parallel)
//   y    in   1     current multiplier bit (serial)
//   p    out  1     registered product bit
module spm #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] x,
  input  logic            y,
  output logic            p
);

  // The running partial sum is kept as a signed value one bit wider than x.
  // Adding a sign-extended x and shifting right arithmetically keeps it
  // bounded by |x|, so SIZE+1 bits hold it and SIZE+2 bits hold the sum.
  logic [SIZE:0]   acc_q, acc_d;
  logic            p_q, p_d;
  logic [SIZE+1:0] sum;

  always_comb begin
    sum   = {acc_q[SIZE], acc_q} + (y ? {{2{x[SIZE-1]}}, x} : '0);
    p_d   = sum[0];
    acc_d = sum[SIZE+1:1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      p_q   <= 1'b0;
    end else begin
      acc_q <= acc_d;
      p_q   <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/spm_ctrl.sv
// spm_ctrl
// Sequencing controller wrapped around the serial-parallel multiplier spm.
// Accepts a signed operand pair over a valid/ready handshake, streams the
// multiplier into spm LSB-first with sign extension, reassembles the serial
// product and returns the 2*WIDTH-bit signed product over a second
// valid/ready handshake. spm is held in reset whenever no operation runs.
// Ports:
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        operand pair offered
//   in_ready   out  1        controller idle and able to accept
//   mc         in   WIDTH    signed multiplicand
//   mp         in   WIDTH    signed multiplier
//   abort      in   1        cancel the operation in flight (RUN only)
//   out_valid  out  1        prod holds a finished result
//   out_ready  in   1        consumer takes the result
//   prod       out  2*WIDTH  signed product mc*mp
//   busy       out  1        multiplication in progress
module spm_ctrl
  import spm_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mc,
  input  logic [WIDTH-1:0]   mp,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy
);

  localparam int                 CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(2 * WIDTH);

  spm_ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     x_q, x_d;
  logic [WIDTH-1:0]     y_sh_q, y_sh_d;
  logic [2*WIDTH-1:0]   prod_sh_q, prod_sh_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 out_valid_q, out_valid_d;
  logic                 spm_rst_q, spm_rst_d;

  logic                 spm_rst;
  logic                 spm_p;
  logic [2*WIDTH-1:0]   prod_cap;

  // spm must clear the instant rst_n drops, not only at the next edge, so
  // the chip reset is ORed in combinationally with the registered hold.
  assign spm_rst = ~rst_n | spm_rst_q;

  spm #(
    .SIZE (WIDTH)
  ) u_spm (
    .clk (clk),
    .rst (spm_rst),
    .x   (x_q),
    .y   (y_sh_q[0]),
    .p   (spm_p)
  );

  // spm.p carries the product bit of the previous RUN cycle, so it is
  // shifted in from the top; after 2*WIDTH captures bit 0 sits at the LSB.
  assign prod_cap = {spm_p, prod_sh_q[2*WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_sh_d      = y_sh_q;
    prod_sh_d   = prod_sh_q;
    prod_d      = prod_q;
    out_valid_d = out_valid_q;
    spm_rst_d   = spm_rst_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d       = mc;
          y_sh_d    = mp;
          cnt_d     = '0;
          prod_sh_d = '0;
          spm_rst_d = 1'b0;
          state_d   = RUN;
        end
      end

      RUN: begin
        // abort is checked first so it also beats the final capture cycle
        if (abort) begin
          spm_rst_d = 1'b1;
          state_d   = IDLE;
        end else begin
          // refilling with the sign bit keeps feeding mp[WIDTH-1] once
          // the real multiplier bits are exhausted
          y_sh_d = {y_sh_q[WIDTH-1], y_sh_q[WIDTH-1:1]};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q != '0) begin
            prod_sh_d = prod_cap;
          end
          if (cnt_q == CNT_LAST) begin
            prod_d      = prod_cap;
            out_valid_d = 1'b1;
            spm_rst_d   = 1'b1;
            state_d     = DONE;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        spm_rst_d   = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_sh_q      <= '0;
      prod_sh_q   <= '0;
      prod_q      <= '0;
      out_valid_q <= 1'b0;
      spm_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_sh_q      <= y_sh_d;
      prod_sh_q   <= prod_sh_d;
      prod_q      <= prod_d;
      out_valid_q <= out_valid_d;
      spm_rst_q   <= spm_rst_d;
    end
  end

  // Outputs come straight from registers; nothing combinational from inputs.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = out_valid_q;
  assign prod      = prod_q;

endmodule

// File: tb/tb_spm_ctrl.sv
// tb_spm_ctrl
// Directed testbench for spm_ctrl (WIDTH=32). A table of operand pairs with
// hand-computed products is run with out_ready tied high, followed by
// hand-written sequences for back-pressure, abort and mid-run reset.
module tb_spm_ctrl;

  localparam int WIDTH   = 32;
  localparam int LATENCY = 2 * WIDTH + 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   mc;
  logic [WIDTH-1:0]   mp;
  logic               abort;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] prod;
  logic               busy;

  spm_ctrl #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mc        (mc),
    .mp        (mp),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]   mc;
    logic [WIDTH-1:0]   mp;
    logic [2*WIDTH-1:0] prod;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  int vecCount = 0;
  int errCount = 0;

  // one comparison; any difference is reported and counted
  task automatic checkOutput(input string name, input logic [2*WIDTH-1:0] act,
                             input logic [2*WIDTH-1:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // offer one operand pair, then wait (bounded) for out_valid; returns the
  // cycle count from the acceptance edge, the product seen and whether
  // busy/in_ready looked right on every RUN cycle
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               output int lat, output logic [2*WIDTH-1:0] res,
                               output logic runOk);
    int n;
    lat   = -1;
    res   = '0;
    runOk = 1'b1;
    n     = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    mc       = a;
    mp       = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        res = prod;
        break;
      end
      if (!busy || in_ready) runOk = 1'b0;
    end
  endtask

  // runs to cnt=k of a freshly accepted operation
  task automatic startAndAdvance(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input int k);
    mc       = a;
    mp       = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (k) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d",
             vecCount, errCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int                 lat;
    logic [2*WIDTH-1:0] res;
    logic               runOk;
    logic               ok;
    logic               seen;

    // 6x7 then -2x9 sit next to each other so they run back-to-back
    vecs[0] = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[2] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[4] = '{32'h0000_0006, 32'h0000_0007, 64'h0000_0000_0000_002A};
    vecs[5] = '{32'hFFFF_FFFE, 32'h0000_0009, 64'hFFFF_FFFF_FFFF_FFEE};
    vecs[6] = '{32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780};
    vecs[7] = '{32'h0000_0000, 32'h8000_0000, 64'h0000_0000_0000_0000};
    vecs[8] = '{32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
    vecs[9] = '{32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    mc        = '0;
    mp        = '0;
    abort     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_flags", 64'({in_ready, out_valid, busy}), 64'b100);
    checkOutput("reset_prod", prod, '0);
    rst_n = 1'b1;

    // table: latency, product, RUN flags, single-cycle out_valid
    for (int v = 0; v < NVEC; v++) begin
      applyStimulus(vecs[v].mc, vecs[v].mp, lat, res, runOk);
      checkOutput($sformatf("vec%0d_latency", v), 64'(lat), 64'(LATENCY));
      checkOutput($sformatf("vec%0d_prod", v), res, vecs[v].prod);
      checkOutput($sformatf("vec%0d_run_flags", v), 64'(runOk), 64'd1);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_after_xfer", v), 64'({out_valid, in_ready}), 64'b01);
    end

    // back-pressure: hold the result for 20 cycles with new operands offered
    out_ready = 1'b0;
    applyStimulus(32'h0000_0010, 32'h0000_0011, lat, res, runOk);
    checkOutput("bp_latency", 64'(lat), 64'(LATENCY));
    checkOutput("bp_prod", res, 64'h0000_0000_0000_0110);
    ok       = 1'b1;
    mc       = 32'd5;
    mp       = 32'd5;
    in_valid = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (prod !== 64'h110 || !out_valid || in_ready || busy) ok = 1'b0;
    end
    in_valid = 1'b0;
    checkOutput("bp_hold_stable", 64'(ok), 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_xfer_flags", 64'({out_valid, in_ready, busy}), 64'b010);
    @(posedge clk); #1;
    checkOutput("bp_single_xfer", 64'({out_valid, busy}), 64'b00);

    // abort at cnt=10
    startAndAdvance(32'd100, 32'd100, 10);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort_idle", 64'({in_ready, busy, out_valid}), 64'b100);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checkOutput("abort_no_result", 64'(seen), 64'd0);
    applyStimulus(32'd2, 32'd2, lat, res, runOk);
    checkOutput("post_abort_latency", 64'(lat), 64'(LATENCY));
    checkOutput("post_abort_prod", res, 64'd4);
    @(posedge clk); #1;

    // abort on the final RUN cycle (cnt=2*WIDTH) still wins
    startAndAdvance(32'd3, 32'd3, 2 * WIDTH);
    checkOutput("last_cycle_busy", 64'(busy), 64'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort_last_cycle", 64'({in_ready, busy, out_valid}), 64'b100);
    checkOutput("abort_last_prod_kept", prod, 64'd4);

    // reset asserted mid-RUN at cnt=40, checked before the next edge
    startAndAdvance(32'd7, 32'd9, 40);
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_flags", 64'({in_ready, out_valid, busy}), 64'b100);
    checkOutput("midrun_reset_prod", prod, '0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    applyStimulus(32'h0000_0001, 32'hFFFF_FFFF, lat, res, runOk);
    checkOutput("post_reset_latency", 64'(lat), 64'(LATENCY));
    checkOutput("post_reset_prod", res, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("post_reset_run_flags", 64'(runOk), 64'd1);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
